// File: rtl/control_pipe_sequencer.sv
// -----------------------------------------------------------------------------
// control_pipe_sequencer
//
// Purpose:
//   Owns the ID/EX control register of the RISC-V pipeline. Each cycle the
//   decoded control bundle in ID is either forwarded into EX or replaced by a
//   bubble (all-zero bundle, ex_valid=0). Bubbles come from load-use hazards
//   and taken-branch flushes. Multi-cycle EX operations hold the EX register
//   in place while the front end is stalled. A saturating counter records how
//   many cycles the front end was stalled.
//
// Ports:
//   clk            in   1            system clock, all state on rising edge
//   reset          in   1            synchronous, active-high reset
//   id_control     in   CTRL_W       decoded control bundle of the ID instr
//   id_valid       in   1            ID holds a real instruction
//   id_rd          in   5            destination register of the ID instr
//   id_rs1         in   5            source register 1 of the ID instr
//   id_rs2         in   5            source register 2 of the ID instr
//   id_uses_rs1    in   1            ID instr reads rs1
//   id_uses_rs2    in   1            ID instr reads rs2
//   id_mem_read    in   1            ID instr is a load
//   id_multicycle  in   1            ID instr needs MC_LATENCY cycles in EX
//   branch_taken   in   1            EX resolved a taken branch/jump
//   ex_control     out  CTRL_W       registered control bundle for EX
//   ex_valid       out  1            EX holds a real instruction
//   stall_if_id    out  1            hold PC and IF/ID this cycle (comb.)
//   flush_if_id    out  1            squash IF/ID this cycle (comb.)
//   busy           out  1            multi-cycle op in progress (comb.)
//   stall_cycles   out  STALL_CNT_W  saturating count of stall cycles
//   dbg_state      out  1            FSM state observation: 0=RUN, 1=MULTI
//
// Handshake:
//   There is no valid/ready pair here; the front end must obey stall_if_id and
//   flush_if_id in the same cycle they are asserted. ex_valid qualifies
//   ex_control: whenever ex_valid=0 the bundle is all-zero.
// -----------------------------------------------------------------------------
module control_pipe_sequencer #(
  parameter int unsigned CTRL_W      = 32,
  parameter int unsigned MC_LATENCY  = 4,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CTRL_W-1:0]      id_control,
  input  logic                   id_valid,
  input  logic [4:0]             id_rd,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic                   id_mem_read,
  input  logic                   id_multicycle,
  input  logic                   branch_taken,
  output logic [CTRL_W-1:0]      ex_control,
  output logic                   ex_valid,
  output logic                   stall_if_id,
  output logic                   flush_if_id,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   dbg_state
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_MULTI = 1'b1
  } state_t;

  // An MC op occupies EX for MC_LATENCY cycles: one RUN cycle that detects
  // it, MC_LATENCY-2 cycles in MULTI, and one final RUN cycle (mc_done set)
  // during which the next instruction is loaded. MULTI exits after the cycle
  // in which mc_cnt reads zero, so the counter starts at MC_LATENCY-3.
  // For MC_LATENCY=2 there are no MULTI cycles: the detect cycle sets mc_done
  // directly. For MC_LATENCY=1 the op is never held at all.
  localparam bit         MC_HOLDS   = (MC_LATENCY > 1);
  localparam bit         MC_USES_MC = (MC_LATENCY > 2);
  localparam logic [7:0] MC_INIT    = MC_USES_MC ? 8'(MC_LATENCY - 3) : 8'd0;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q;
  logic [7:0]             mc_cnt_q;
  logic                   mc_done_q;
  logic [CTRL_W-1:0]      ex_control_q;
  logic                   ex_valid_q;
  logic [4:0]             ex_rd_q;
  logic                   ex_mem_read_q;
  logic                   ex_mc_q;
  logic [STALL_CNT_W-1:0] stall_cycles_q;
  logic [STALL_CNT_W-1:0] stall_cycles_d;

  logic load_use;
  logic mc_start;
  logic in_run;

  assign in_run = (state_q == ST_RUN);

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd_q)) |
                     (id_uses_rs2 & (id_rs2 == ex_rd_q)));

  // First cycle of an MC op sitting in EX; mc_done blocks re-detection of the
  // same op after its hold period has finished.
  assign mc_start = in_run & ex_valid_q & ex_mc_q & MC_HOLDS & ~mc_done_q;

  // Priority in RUN: MC start, then branch flush, then load-use stall.
  // In MULTI the front end is simply held; branch_taken cannot occur there.
  assign stall_if_id = ~in_run | mc_start | (~branch_taken & load_use);
  assign flush_if_id = in_run & ~mc_start & branch_taken;
  assign busy        = ~in_run | mc_start;

  assign stall_cycles_d = (stall_if_id && (stall_cycles_q != CNT_MAX))
                          ? stall_cycles_q + 1'b1 : stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      mc_cnt_q       <= 8'd0;
      mc_done_q      <= 1'b0;
      ex_control_q   <= '0;
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_mem_read_q  <= 1'b0;
      ex_mc_q        <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      case (state_q)
        ST_RUN: begin
          if (mc_start) begin
            // EX register holds the MC op.
            if (MC_USES_MC) begin
              state_q  <= ST_MULTI;
              mc_cnt_q <= MC_INIT;
            end else begin
              mc_done_q <= 1'b1;
            end
          end else if (branch_taken || load_use) begin
            // Bubble: all-zero bundle means no writes and no memory access.
            ex_control_q  <= '0;
            ex_valid_q    <= 1'b0;
            ex_rd_q       <= 5'd0;
            ex_mem_read_q <= 1'b0;
            ex_mc_q       <= 1'b0;
            mc_done_q     <= 1'b0;
          end else begin
            // Normal advance. An invalid ID slot becomes a clean bubble so a
            // stale bundle can never reach EX.
            ex_control_q  <= id_valid ? id_control : '0;
            ex_valid_q    <= id_valid;
            ex_rd_q       <= id_valid ? id_rd : 5'd0;
            ex_mem_read_q <= id_valid & id_mem_read;
            ex_mc_q       <= id_valid & id_multicycle;
            mc_done_q     <= 1'b0;
          end
        end
        ST_MULTI: begin
          if (mc_cnt_q == 8'd0) begin
            state_q   <= ST_RUN;
            mc_done_q <= 1'b1;
          end else begin
            mc_cnt_q <= mc_cnt_q - 8'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign ex_control   = ex_control_q;
  assign ex_valid     = ex_valid_q;
  assign stall_cycles = stall_cycles_q;
  assign dbg_state    = (state_q == ST_MULTI);

endmodule

// File: tb/tb_control_pipe_sequencer.sv
module tb_control_pipe_sequencer;

  localparam int CTRL_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CTRL_W-1:0] id_control = '0;
  logic              id_valid = 1'b0;
  logic [4:0]        id_rd = 5'd0;
  logic [4:0]        id_rs1 = 5'd0;
  logic [4:0]        id_rs2 = 5'd0;
  logic              id_uses_rs1 = 1'b0;
  logic              id_uses_rs2 = 1'b0;
  logic              id_mem_read = 1'b0;
  logic              id_multicycle = 1'b0;
  logic              branch_taken = 1'b0;

  logic [CTRL_W-1:0] ex_control;
  logic              ex_valid;
  logic              stall_if_id;
  logic              flush_if_id;
  logic              busy;
  logic [15:0]       stall_cycles;
  logic              dbg_state;

  logic [CTRL_W-1:0] s_ex_control;
  logic              s_ex_valid;
  logic              s_stall_if_id;
  logic              s_flush_if_id;
  logic              s_busy;
  logic [1:0]        s_stall_cycles;
  logic              s_dbg_state;

  // Control bundles (arbitrary distinct non-zero encodings).
  localparam logic [31:0] C_LW  = 32'h0000_1003;
  localparam logic [31:0] C_ADD = 32'h0000_2033;
  localparam logic [31:0] C_SUB = 32'h4000_0033;
  localparam logic [31:0] C_MUL = 32'h0200_0033;
  localparam logic [31:0] C_OR  = 32'h0000_6033;
  localparam logic [31:0] C_JNK = 32'hDEAD_BEEF;

  logic [CTRL_W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  control_pipe_sequencer #(.CTRL_W(32), .MC_LATENCY(4), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .id_control(id_control), .id_valid(id_valid),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
    .branch_taken(branch_taken), .ex_control(ex_control), .ex_valid(ex_valid),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .busy(busy),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  control_pipe_sequencer #(.CTRL_W(32), .MC_LATENCY(4), .STALL_CNT_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .id_control(id_control), .id_valid(id_valid),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_mem_read(id_mem_read), .id_multicycle(id_multicycle),
    .branch_taken(branch_taken), .ex_control(s_ex_control), .ex_valid(s_ex_valid),
    .stall_if_id(s_stall_if_id), .flush_if_id(s_flush_if_id), .busy(s_busy),
    .stall_cycles(s_stall_cycles), .dbg_state(s_dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (actual=running required=done)");
    $fatal(1, "timeout");
  end

  // Checking helper
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_id(input logic [31:0] ctrl, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2,
                          input logic mr, input logic mc);
    id_control    = ctrl;
    id_valid      = 1'b1;
    id_rd         = rd;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_uses_rs1   = u1;
    id_uses_rs2   = u2;
    id_mem_read   = mr;
    id_multicycle = mc;
  endtask

  task automatic idle_id();
    id_control    = '0;
    id_valid      = 1'b0;
    id_rd         = 5'd0;
    id_rs1        = 5'd0;
    id_rs2        = 5'd0;
    id_uses_rs1   = 1'b0;
    id_uses_rs2   = 1'b0;
    id_mem_read   = 1'b0;
    id_multicycle = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    branch_taken = 1'b0;
    idle_id();
    tick();
    tick();
    exp_q.delete();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every cycle EX holds a real instruction, one expected
  // bundle is popped; bubble cycles must present an all-zero bundle.
  always @(negedge clk) begin
    if (!reset) begin
      if (ex_valid) begin
        if (exp_q.size() == 0) begin
          chk("ex_unexpected_valid", 32'd1, 32'd0);
        end else begin
          chk("ex_control", ex_control, exp_q.pop_front());
        end
      end else begin
        chk("bubble_ctrl", ex_control, 32'd0);
      end
    end
  end

  // Stimulus
  initial begin
    do_reset();
    settle();
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Plain flow, including an invalid slot carrying junk control bits.
    tick();
    drive_id(C_ADD, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0); exp_q.push_back(C_ADD);
    tick();
    drive_id(C_OR, 5'd4, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0); exp_q.push_back(C_OR);
    tick();
    drive_id(C_JNK, 5'd4, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0); id_valid = 1'b0;
    tick();
    idle_id();
    settle();
    chk("invalid_slot_valid", {31'd0, ex_valid}, 32'd0);
    chk("flow_no_stall", {16'd0, stall_cycles}, 32'd0);

    // Reset in the middle of an MC op.
    tick();
    drive_id(C_MUL, 5'd6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_q.push_back(C_MUL); exp_q.push_back(C_MUL);
    tick();
    idle_id();
    settle();
    chk("mcr_busy_c1", {31'd0, busy}, 32'd1);
    chk("mcr_stall_c1", {31'd0, stall_if_id}, 32'd1);
    chk("mcr_state_c1", {31'd0, dbg_state}, 32'd0);
    tick();
    settle();
    chk("mcr_state_c2", {31'd0, dbg_state}, 32'd1);
    chk("mcr_busy_c2", {31'd0, busy}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mcr_queue_drained", exp_q.size(), 32'd0);
    settle();
    chk("mcr_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("mcr_ex_control", ex_control, 32'd0);
    chk("mcr_stall_cycles", {16'd0, stall_cycles}, 32'd0);
    chk("mcr_busy", {31'd0, busy}, 32'd0);
    chk("mcr_state", {31'd0, dbg_state}, 32'd0);

    // Load-use: lw x5 then add reading x5 via rs2.
    do_reset();
    drive_id(C_LW, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(C_LW);
    tick();
    drive_id(C_ADD, 5'd7, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    chk("lu_stall", {31'd0, stall_if_id}, 32'd1);
    chk("lu_flush", {31'd0, flush_if_id}, 32'd0);
    tick();
    settle();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_once", {31'd0, stall_if_id}, 32'd0);
    exp_q.push_back(C_ADD);
    tick();
    idle_id();
    settle();
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_stall_cycles", {16'd0, stall_cycles}, 32'd1);

    // Load to x0: never a hazard.
    do_reset();
    drive_id(C_LW, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(C_LW);
    tick();
    drive_id(C_ADD, 5'd7, 5'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); exp_q.push_back(C_ADD);
    settle();
    chk("x0_no_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    idle_id();
    settle();
    chk("x0_add_valid", {31'd0, ex_valid}, 32'd1);
    chk("x0_stall_cycles", {16'd0, stall_cycles}, 32'd0);

    // rs2 matches but is not read: no hazard.
    do_reset();
    drive_id(C_LW, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(C_LW);
    tick();
    drive_id(C_ADD, 5'd7, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(C_ADD);
    settle();
    chk("nors2_no_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    idle_id();
    settle();
    chk("nors2_stall_cycles", {16'd0, stall_cycles}, 32'd0);

    // Taken branch with a load-use also present: flush wins.
    do_reset();
    drive_id(C_LW, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(C_LW);
    tick();
    drive_id(C_ADD, 5'd7, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    branch_taken = 1'b1;
    settle();
    chk("br_flush", {31'd0, flush_if_id}, 32'd1);
    chk("br_stall", {31'd0, stall_if_id}, 32'd0);
    tick();
    branch_taken = 1'b0;
    idle_id();
    settle();
    chk("br_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("br_stall_cycles", {16'd0, stall_cycles}, 32'd0);

    // Multi-cycle op, MC_LATENCY=4.
    do_reset();
    drive_id(C_MUL, 5'd8, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) exp_q.push_back(C_MUL);
    tick();
    drive_id(C_SUB, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk($sformatf("mc_stall_c%0d", c), {31'd0, stall_if_id}, 32'd1);
      chk($sformatf("mc_busy_c%0d", c), {31'd0, busy}, 32'd1);
      tick();
    end
    settle();
    chk("mc_stall_c4", {31'd0, stall_if_id}, 32'd0);
    chk("mc_busy_c4", {31'd0, busy}, 32'd0);
    chk("mc_ctrl_c4", ex_control, C_MUL);
    exp_q.push_back(C_SUB);
    tick();
    idle_id();
    settle();
    chk("mc_sub_valid", {31'd0, ex_valid}, 32'd1);
    chk("mc_stall_cycles", {16'd0, stall_cycles}, 32'd3);
    tick();

    // Five load-use stalls: 2-bit counter saturates at 3.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_id(C_LW, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exp_q.push_back(C_LW);
      tick();
      drive_id(C_ADD, 5'd7, 5'd5, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      chk($sformatf("sat_stall_%0d", i), {31'd0, stall_if_id}, 32'd1);
      tick();
      exp_q.push_back(C_ADD);
      settle();
      chk($sformatf("sat_cnt_%0d", i), {30'd0, s_stall_cycles}, (i < 3) ? i + 1 : 3);
      tick();
    end
    idle_id();
    tick();
    settle();
    chk("sat_final_small", {30'd0, s_stall_cycles}, 32'd3);
    chk("sat_final_wide", {16'd0, stall_cycles}, 32'd5);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
